// File: rtl/lane_dly_pkg.sv
// lane_dly_pkg: op codes, FSM state encoding and lane target helpers for lane_delay_seq
package lane_dly_pkg;
  typedef enum logic [1:0] {
    OP_LOAD      = 2'd0,
    OP_LOAD_SET  = 2'd1,
    OP_BCAST_SET = 2'd2,
    OP_SET_ONLY  = 2'd3
  } op_t;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GAP  = 2'd2,
    ST_SET  = 2'd3
  } state_t;
  function automatic int sel_dqs(int dq_per_lane);
    return dq_per_lane;
  endfunction
  function automatic int sel_dm(int dq_per_lane);
    return dq_per_lane + 1;
  endfunction
endpackage

// File: rtl/lane_dly_decode.sv
// lane_dly_decode: per-lane sel/dir/enable to one-hot output/input delay load strobes plus target-valid flag
module lane_dly_decode
  import lane_dly_pkg::*;
#(
  parameter int DQ_PER_LANE = 8,
  localparam int NT = DQ_PER_LANE + 2,
  localparam int SEL_W = $clog2(NT)
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             dir,
  input  logic             en,
  output logic [NT-1:0]    ld_odly,
  output logic [NT-2:0]    ld_idly,
  output logic             valid
);
  // input delays exist for dq and dqs only, output delays additionally for dm
  always_comb begin
    valid = int'(sel) <= (dir ? sel_dqs(DQ_PER_LANE) : sel_dm(DQ_PER_LANE));
    ld_odly = en && valid && !dir ? NT'(1) << sel : '0;
    ld_idly = en && valid && dir ? (NT-1)'(1) << sel : '0;
  end
endmodule

// File: rtl/lane_delay_seq.sv
// lane_delay_seq: IODELAY programming sequencer for byte lanes; LANE_DLY_READBACK_EN adds a shadow readback RAM
module lane_delay_seq
  import lane_dly_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int DQ_PER_LANE = 8,
  parameter int DLY_WIDTH = 8,
  parameter int SET_GAP = 2,
  localparam int NT = DQ_PER_LANE + 2,
  localparam int SEL_W = $clog2(NT),
  localparam int LANE_W = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1
) (
  input  logic                           clk_div,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic [LANE_W-1:0]              cmd_lane,
  input  logic                           cmd_dir,
  input  logic [SEL_W-1:0]               cmd_sel,
  input  logic [DLY_WIDTH-1:0]           cmd_data,
  output logic [NUM_LANES*DLY_WIDTH-1:0] dly_data,
  output logic [NUM_LANES*NT-1:0]        ld_odly,
  output logic [NUM_LANES*(NT-1)-1:0]    ld_idly,
  output logic [NUM_LANES-1:0]           set,
  output logic                           done,
`ifdef LANE_DLY_READBACK_EN
  input  logic [LANE_W-1:0]              rd_lane,
  input  logic                           rd_dir,
  input  logic [SEL_W-1:0]               rd_sel,
  output logic [DLY_WIDTH-1:0]           rd_data,
`endif
  output logic                           err
);
  localparam logic [3:0] GAP_LAST = 4'(SET_GAP == 0 ? 0 : SET_GAP - 1);
  state_t state, state_nx;
  op_t op_q, op_in;
  logic [3:0] gap_cnt;
  logic [NUM_LANES-1:0] pending, hit, dec_ok;
  logic [NUM_LANES-1:0][NT-1:0] dec_o;
  logic [NUM_LANES-1:0][NT-2:0] dec_i;
  logic accept, bcast, is_load, tgt_ok, load_ok;
  assign cmd_ready = state == ST_IDLE && !rst;
  assign accept = cmd_valid && cmd_ready;
  assign op_in = op_t'(cmd_op);
  assign bcast = op_in == OP_BCAST_SET;
  assign is_load = op_in != OP_SET_ONLY;
  assign tgt_ok = &dec_ok && |hit;
  assign load_ok = accept && is_load && tgt_ok;
  assign set = state == ST_SET ? pending : '0;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign hit[i] = bcast || cmd_lane == LANE_W'(i);
    lane_dly_decode #(.DQ_PER_LANE(DQ_PER_LANE)) u_dec (
      .sel(cmd_sel),
      .dir(cmd_dir),
      .en(hit[i]),
      .ld_odly(dec_o[i]),
      .ld_idly(dec_i[i]),
      .valid(dec_ok[i])
    );
  end
  // next state: invalid targets finish in IDLE, SET_ONLY jumps straight to SET
  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE: state_nx = !accept ? ST_IDLE : !is_load ? ST_SET : !tgt_ok ? ST_IDLE : ST_LOAD;
      ST_LOAD: state_nx = op_q == OP_LOAD ? ST_IDLE : SET_GAP == 0 ? ST_SET : ST_GAP;
      ST_GAP:  state_nx = gap_cnt == GAP_LAST ? ST_SET : ST_GAP;
      default: state_nx = ST_IDLE;
    endcase
  end
  // state, gap counter, pending mask, strobes, done and sticky error
  always_ff @(posedge clk_div) begin
    if (rst) begin
      state <= ST_IDLE;
      op_q <= OP_LOAD;
      gap_cnt <= '0;
      pending <= '0;
      ld_odly <= '0;
      ld_idly <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) op_q <= op_in;
      gap_cnt <= state == ST_GAP ? gap_cnt + 4'd1 : '0;
      pending <= state == ST_SET ? '0 : load_ok ? pending | hit : pending;
      ld_odly <= load_ok ? dec_o : '0;
      ld_idly <= load_ok ? dec_i : '0;
      done <= (state == ST_LOAD && op_q == OP_LOAD) || state == ST_SET || (accept && is_load && !tgt_ok);
      err <= accept && !is_load ? 1'b0 : accept && !tgt_ok ? 1'b1 : err;
    end
  end
  // delay value bus only moves on a valid load that hits the lane
  always_ff @(posedge clk_div) begin
    for (int l = 0; l < NUM_LANES; l++)
      if (rst) dly_data[l*DLY_WIDTH +: DLY_WIDTH] <= '0;
      else if (load_ok && hit[l]) dly_data[l*DLY_WIDTH +: DLY_WIDTH] <= cmd_data;
  end
`ifdef LANE_DLY_READBACK_EN
  localparam int NE = 2 * NT - 1;
  logic [DLY_WIDTH-1:0] shadow [NUM_LANES][NE];
  logic rd_ok;
  int wr_idx, rd_idx;
  assign wr_idx = cmd_dir ? NT + int'(cmd_sel) : int'(cmd_sel);
  assign rd_idx = rd_dir ? NT + int'(rd_sel) : int'(rd_sel);
  assign rd_ok = int'(rd_lane) < NUM_LANES && int'(rd_sel) < (rd_dir ? NT - 1 : NT);
  // shadow copy of every loaded value: output delays first, input delays at NT+sel
  always_ff @(posedge clk_div) begin
    if (rst) begin
      for (int l = 0; l < NUM_LANES; l++)
        for (int e = 0; e < NE; e++) shadow[l][e] <= '0;
      rd_data <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++)
        if (load_ok && hit[l]) shadow[l][wr_idx] <= cmd_data;
      rd_data <= rd_ok ? shadow[rd_lane][rd_idx] : '0;
    end
  end
`endif
endmodule

// File: tb/tb_lane_delay_seq.sv
// tb_lane_delay_seq: directed and randomized commands against a command-level timeline model
module tb_lane_delay_seq;
  localparam int NL = 2, DQ = 8, DW = 8, GAP = 2, NT = DQ + 2, SW = $clog2(NT), LW = 1;
  logic clk_div = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_dir = 1'b0;
  logic cmd_ready, done, err;
  logic [1:0] cmd_op = '0;
  logic [LW-1:0] cmd_lane = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [NL*DW-1:0] dly_data;
  logic [NL*NT-1:0] ld_odly;
  logic [NL*(NT-1)-1:0] ld_idly;
  logic [NL-1:0] set;
`ifdef LANE_DLY_READBACK_EN
  logic [LW-1:0] rd_lane = '0;
  logic rd_dir = 1'b0;
  logic [SW-1:0] rd_sel = '0;
  logic [DW-1:0] rd_data, exp_rd = '0;
  logic [DW-1:0] shadow_m [NL][2*NT-1];
`endif
  int n_chk = 0, n_err = 0;
  logic [DW-1:0] dly_m [NL];
  logic [NL-1:0] pend_m;
  logic err_m;

  always #5 clk_div = ~clk_div;

  lane_delay_seq #(.NUM_LANES(NL), .DQ_PER_LANE(DQ), .DLY_WIDTH(DW), .SET_GAP(GAP)) dut (
    .clk_div(clk_div), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_lane(cmd_lane), .cmd_dir(cmd_dir), .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .dly_data(dly_data), .ld_odly(ld_odly), .ld_idly(ld_idly), .set(set), .done(done),
`ifdef LANE_DLY_READBACK_EN
    .rd_lane(rd_lane), .rd_dir(rd_dir), .rd_sel(rd_sel), .rd_data(rd_data),
`endif
    .err(err)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NL*DW-1:0] dly_pack();
    logic [NL*DW-1:0] v;
    for (int l = 0; l < NL; l++) v[l*DW +: DW] = dly_m[l];
    return v;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) dly_m[l] = '0;
    pend_m = '0;
    err_m = 1'b0;
`ifdef LANE_DLY_READBACK_EN
    for (int l = 0; l < NL; l++)
      for (int e = 0; e < 2*NT-1; e++) shadow_m[l][e] = '0;
`endif
  endtask

  task automatic step();
`ifdef LANE_DLY_READBACK_EN
    exp_rd = rst ? '0 : int'(rd_sel) < (rd_dir ? NT - 1 : NT) ? shadow_m[rd_lane][rd_dir ? NT + int'(rd_sel) : int'(rd_sel)] : '0;
`endif
    @(negedge clk_div);
`ifdef LANE_DLY_READBACK_EN
    check("rd_data", rd_data, exp_rd);
    rd_lane = LW'($urandom);
    rd_dir = 1'($urandom);
    rd_sel = SW'($urandom_range(0, NT + 1));
`endif
  endtask

  task automatic quiet(string tag, logic exp_ready);
    check({tag, "_ld_odly"}, ld_odly, '0);
    check({tag, "_ld_idly"}, ld_idly, '0);
    check({tag, "_set"}, set, '0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ready"}, cmd_ready, exp_ready);
    check({tag, "_err"}, err, err_m);
    check({tag, "_dly"}, dly_data, dly_pack());
  endtask

  task automatic do_reset(bit with_cmd);
    rst = 1'b1;
    if (with_cmd) begin
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_lane = 1'b1; cmd_dir = 1'b0; cmd_sel = 4'd2; cmd_data = 8'hC3;
    end
    step();
    model_reset();
    quiet("rst", 1'b0);
    rst = 1'b0;
    cmd_valid = 1'b0;
    step();
    quiet("post_rst", 1'b1);
  endtask

  task automatic idle_cycle();
    step();
    quiet("idle", 1'b1);
  endtask

  task automatic run_cmd(int op, int lane, int dir, int sel, int data, int rst_at = 0);
    logic [NL-1:0] set_v;
    logic [NL*NT-1:0] eo;
    logic [NL*(NT-1)-1:0] ei;
    int len, set_k;
    bit ok;
    ok = op == 3 || (sel < NT - dir && (op == 2 || lane < NL));
    eo = '0; ei = '0; set_v = '0; set_k = 0;
    check("ready_pre", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_lane = LW'(lane); cmd_dir = 1'(dir); cmd_sel = SW'(sel); cmd_data = DW'(data);
    step();
    if (op == 3) begin
      len = 2; set_k = 1; set_v = pend_m; pend_m = '0; err_m = 1'b0;
    end else if (!ok) begin
      len = 1; err_m = 1'b1;
    end else begin
      for (int l = 0; l < NL; l++)
        if (op == 2 || l == lane) begin
          pend_m[l] = 1'b1;
          dly_m[l] = DW'(data);
          if (dir != 0) ei[l*(NT-1) + sel] = 1'b1;
          else eo[l*NT + sel] = 1'b1;
`ifdef LANE_DLY_READBACK_EN
          shadow_m[l][dir != 0 ? NT + sel : sel] = DW'(data);
`endif
        end
      len = op == 0 ? 2 : 3 + GAP;
      set_k = op == 0 ? 0 : 2 + GAP;
      set_v = pend_m;
      if (op != 0) pend_m = '0;
    end
    for (int k = 1; k <= len; k++) begin
      check("ld_odly", ld_odly, k == 1 ? eo : '0);
      check("ld_idly", ld_idly, k == 1 ? ei : '0);
      check("set", set, k == set_k ? set_v : '0);
      check("done", done, k == len);
      check("err", err, err_m);
      check("dly_data", dly_data, dly_pack());
      if (k < len) check("busy_ready", cmd_ready, 0);
      if (k == rst_at) begin
        cmd_valid = 1'b0;
        do_reset(0);
        return;
      end
      if (k < len) begin
        cmd_valid = 1'($urandom); cmd_op = 2'($urandom); cmd_lane = LW'($urandom);
        cmd_dir = 1'($urandom); cmd_sel = SW'($urandom); cmd_data = DW'($urandom);
        step();
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    int op, sel, rat;
    model_reset();
    do_reset(0);
    run_cmd(0, 1, 0, 3, 'h5A);
    check("t1_lane1_5a", dly_data[2*DW-1:DW], 8'h5A);
    run_cmd(0, 1, 1, 0, 'h33);
`ifdef LANE_DLY_READBACK_EN
    rd_lane = 1'b1; rd_dir = 1'b1; rd_sel = 4'd0;
    step();
    check("rb_written", rd_data, 8'h33);
    rd_lane = 1'b0; rd_dir = 1'b0; rd_sel = 4'd7;
    step();
    check("rb_unwritten", rd_data, 8'h00);
`endif
    run_cmd(3, 0, 0, 0, 0);
    run_cmd(1, 0, 1, 8, 'h21);
    run_cmd(2, 0, 0, 9, 'hFF);
    check("t3_bcast_ffff", dly_data, 16'hFFFF);
    run_cmd(0, 0, 1, 9, 'h11);
    check("t4_err_dm_in", err, 1);
    run_cmd(0, 1, 0, 12, 'h12);
    run_cmd(3, 0, 0, 0, 0);
    check("t4_err_clear", err, 0);
    run_cmd(1, 1, 0, 4, 'h77, 2);
    run_cmd(3, 1, 0, 0, 0);
    run_cmd(0, 0, 0, 5, 'h9C);
    do_reset(1);
    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 3);
      sel = $urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, NT - 1);
      rat = $urandom_range(0, 29) == 0 ? $urandom_range(1, 3) : 0;
      run_cmd(op, $urandom_range(0, NL - 1), $urandom_range(0, 1), sel, $urandom_range(0, 255), rat);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
